mem_access_unit: RTL and testbench

- Initiator-side load/store controller that sits between the MEM pipeline stage and the 8-bit-wide data memory.
- Accepts one byte or halfword request per transaction through a valid/ready handshake.
- Sequences the request into one or two byte accesses on the memory's address, write_data, read and write lines.
- Returns assembled load data with a one-cycle response pulse. The pipeline stalls while busy is high.

---
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and an 8-bit data memory.
// Splits byte/halfword requests into one or two byte accesses and assembles load results.
module mem_access_unit #(
   parameter int ADDR_W     = 8,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              resp_valid,
   output logic [15:0]       resp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [7:0]        mem_read_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BYTE0 = 2'd1;
   localparam logic [1:0] BYTE1 = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [15:0]       wdata_reg;
   logic              write_reg;
   logic              size_reg;
   logic              sign_reg;
   logic [7:0]        first_byte_reg;
   logic [15:0]       rdata_reg;

   logic [7:0]        byte0_wdata;
   logic [7:0]        byte1_wdata;

   // BYTE0 always targets addr; which half of wdata lives there depends on byte order.
   assign byte0_wdata = (BIG_ENDIAN && size_reg) ? wdata_reg[15:8] : wdata_reg[7:0];
   assign byte1_wdata = BIG_ENDIAN ? wdata_reg[7:0] : wdata_reg[15:8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         write_reg      <= 1'b0;
         size_reg       <= 1'b0;
         sign_reg       <= 1'b0;
         first_byte_reg <= '0;
         rdata_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  addr_reg  <= req_addr;
                  wdata_reg <= req_wdata;
                  write_reg <= req_write;
                  size_reg  <= req_size;
                  sign_reg  <= req_signed;
                  state_reg <= BYTE0;
               end
            end
            BYTE0: begin
               if (!write_reg) begin
                  first_byte_reg <= mem_read_data;
                  if (!size_reg) begin
                     rdata_reg <= {{8{sign_reg & mem_read_data[7]}}, mem_read_data};
                  end
               end
               state_reg <= size_reg ? BYTE1 : DONE;
            end
            BYTE1: begin
               if (!write_reg) begin
                  rdata_reg <= BIG_ENDIAN ? {first_byte_reg, mem_read_data}
                                          : {mem_read_data, first_byte_reg};
               end
               state_reg <= DONE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // Memory side is decoded purely from registered state so req_* never reaches it combinationally.
   always_comb begin
      mem_address    = '0;
      mem_write_data = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      case (state_reg)
         BYTE0: begin
            mem_address    = addr_reg;
            mem_write_data = byte0_wdata;
            mem_read       = ~write_reg;
            mem_write      = write_reg;
         end
         BYTE1: begin
            mem_address    = addr_reg + ADDR_W'(1);
            mem_write_data = byte1_wdata;
            mem_read       = ~write_reg;
            mem_write      = write_reg;
         end
         default: begin
         end
      endcase
   end

   assign busy       = (state_reg != IDLE);
   assign req_ready  = ~busy;
   assign resp_valid = (state_reg == DONE);
   assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a behavioural 256x8 memory.
// Table-driven transactions plus hand-written reset-abort and back-to-back handshake sequences.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_size;
   logic        req_signed;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        busy;
   logic [7:0]  mem_address;
   logic [7:0]  mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [7:0]  mem_read_data;

   logic [7:0]  mem [0:255];
   logic        tb_we;
   logic [7:0]  tb_wa;
   logic [7:0]  tb_wd;

   int total;
   int bad;
   int resp_count;
   int overlap_count;

   mem_access_unit #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .busy           (busy),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_address];

   always @(posedge clk) begin
      if (mem_write) mem[mem_address] <= mem_write_data;
      else if (tb_we) mem[tb_wa] <= tb_wd;
   end

   initial begin
      resp_count    = 0;
      overlap_count = 0;
   end

   always @(negedge clk) begin
      if (resp_valid) resp_count++;
      if (mem_read && mem_write) overlap_count++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Issues one request starting at a negedge in IDLE; returns at a negedge back in IDLE.
   task automatic do_req(input logic w, input logic sz, input logic sg, input logic [7:0] a,
                         input logic [15:0] wd, output int lat, output logic [15:0] rd,
                         output int wr_cycles, output logic [7:0] first_waddr);
      lat = -1;
      rd = 16'hxxxx;
      wr_cycles = 0;
      first_waddr = 8'h00;
      req_valid = 1'b1;
      req_write = w;
      req_size = sz;
      req_signed = sg;
      req_addr = a;
      req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (mem_write) begin
            if (wr_cycles == 0) first_waddr = mem_address;
            wr_cycles++;
         end
         if (resp_valid) begin
            lat = c;
            rd = resp_rdata;
            break;
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic        w;
      logic        sz;
      logic        sg;
      logic [7:0]  a;
      logic [15:0] wd;
      logic [15:0] exp_rd;
      int          exp_lat;
      int          exp_wr;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int          lat;
      logic [15:0] rd;
      int          wr;
      logic [7:0]  fwa;
      int          acc;
      int          nresp;
      int          ready_err;
      int          resp_cyc [4];
      logic [15:0] resp_val [4];
      logic [7:0]  hs_addr [3];
      logic [15:0] hs_exp [3];
      logic        take;

      total = 0;
      bad = 0;

      // w, sz, sg, addr, wdata, expected resp_rdata (loads: result, stores: retained), latency, write cycles
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h64, 16'h005A, 16'h0000, 2, 1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h64, 16'h0000, 16'h005A, 2, 0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h65, 16'hCC80, 16'h005A, 2, 1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 8'h65, 16'h0000, 16'hFF80, 2, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h65, 16'h0000, 16'h0080, 2, 0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h66, 16'h1234, 16'h0080, 3, 2};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h66, 16'h0000, 16'h1234, 3, 0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 16'hA1B2, 16'h1234, 3, 2};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 16'hA1B2, 3, 0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h67, 16'h0000, 16'h0012, 2, 0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000, 16'hFFB2, 2, 0};

      rst = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_size = 1'b0;
      req_signed = 1'b0;
      req_addr = 8'h00;
      req_wdata = 16'h0000;
      tb_we = 1'b0;
      tb_wa = 8'h00;
      tb_wd = 8'h00;

      repeat (2) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", 32'(resp_rdata), 32'h0);
      chk("reset_mem_read", 32'(mem_read), 32'd0);
      chk("reset_mem_write", 32'(mem_write), 32'd0);
      chk("reset_mem_address", 32'(mem_address), 32'h0);
      chk("reset_mem_write_data", 32'(mem_write_data), 32'h0);

      tb_we = 1'b1; tb_wa = 8'h11; tb_wd = 8'h77;
      @(negedge clk);
      tb_wa = 8'h10; tb_wd = 8'h00;
      @(negedge clk);
      tb_we = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      // Halfword store aborted by an asynchronous reset while in BYTE1.
      req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_signed = 1'b0;
      req_addr = 8'h10; req_wdata = 16'hBEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_b0_write", 32'(mem_write), 32'd1);
      chk("abort_b0_addr", 32'(mem_address), 32'h10);
      chk("abort_b0_data", 32'(mem_write_data), 32'hEF);
      @(negedge clk);
      chk("abort_b1_addr", 32'(mem_address), 32'h11);
      chk("abort_b1_data", 32'(mem_write_data), 32'hBE);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_mem_write", 32'(mem_write), 32'd0);
      chk("abort_mem_address", 32'(mem_address), 32'h0);
      chk("abort_mem_write_data", 32'(mem_write_data), 32'h0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_mem10", 32'(mem[8'h10]), 32'hEF);
      chk("abort_mem11", 32'(mem[8'h11]), 32'h77);
      chk("abort_no_resp", 32'(resp_count), 32'd0);
      $display("txn abort: halfword store BEEF @10 cut by reset in BYTE1");

      for (int i = 0; i < 11; i++) begin
         do_req(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, lat, rd, wr, fwa);
         $display("txn %0d: write=%0d size=%0d signed=%0d addr=%h wdata=%h rdata=%h lat=%0d writes=%0d",
                  i, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, rd, lat, wr);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
         chk($sformatf("vec%0d_write_cycles", i), 32'(wr), 32'(vecs[i].exp_wr));
         if (vecs[i].exp_wr > 0) chk($sformatf("vec%0d_first_waddr", i), 32'(fwa), 32'(vecs[i].a));
      end

      chk("mem64", 32'(mem[8'h64]), 32'h5A);
      chk("mem65", 32'(mem[8'h65]), 32'h80);
      chk("mem66", 32'(mem[8'h66]), 32'h34);
      chk("mem67", 32'(mem[8'h67]), 32'h12);
      chk("memFF", 32'(mem[8'hFF]), 32'hB2);
      chk("mem00", 32'(mem[8'h00]), 32'hA1);

      // Three byte loads queued with req_valid held high throughout.
      hs_addr[0] = 8'h64; hs_exp[0] = 16'h005A;
      hs_addr[1] = 8'h65; hs_exp[1] = 16'h0080;
      hs_addr[2] = 8'h67; hs_exp[2] = 16'h0012;
      acc = 0;
      nresp = 0;
      ready_err = 0;
      for (int k = 0; k < 4; k++) begin
         resp_cyc[k] = -100;
         resp_val[k] = 16'h0000;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_write = 1'b0; req_size = 1'b0; req_signed = 1'b0;
      req_addr = hs_addr[0];
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (req_ready !== ~busy) ready_err++;
         if (resp_valid && nresp < 4) begin
            resp_cyc[nresp] = c;
            resp_val[nresp] = resp_rdata;
            nresp++;
         end
         take = req_ready && req_valid;
         if (take) acc++;
         @(posedge clk);
         #1;
         if (take) begin
            if (acc >= 3) req_valid = 1'b0;
            else req_addr = hs_addr[acc];
         end
      end
      for (int k = 0; k < 3; k++) begin
         $display("txn hs%0d: load addr=%h rdata=%h at cycle %0d", k, hs_addr[k], resp_val[k], resp_cyc[k]);
      end
      chk("hs_accepts", 32'(acc), 32'd3);
      chk("hs_resp_pulses", 32'(nresp), 32'd3);
      chk("hs_first_resp_cycle", 32'(resp_cyc[0]), 32'd2);
      chk("hs_spacing01", 32'(resp_cyc[1] - resp_cyc[0]), 32'd3);
      chk("hs_spacing12", 32'(resp_cyc[2] - resp_cyc[1]), 32'd3);
      chk("hs_rdata0", 32'(resp_val[0]), 32'(hs_exp[0]));
      chk("hs_rdata1", 32'(resp_val[1]), 32'(hs_exp[1]));
      chk("hs_rdata2", 32'(resp_val[2]), 32'(hs_exp[2]));
      chk("hs_ready_vs_busy", 32'(ready_err), 32'd0);
      chk("read_write_overlap", 32'(overlap_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
